// File: rtl/cru_sams_mapper.sv
// cru_sams_mapper
//   CRU expansion-card decoder plus SAMS-style 4K page mapper.
//   - Serial CRU bit writes for cards at >1000..>1F00 drive a one-hot DSR
//     select (bit 0 of each card) and the mapper control bits
//     (bit 1 transparent, bit 2 wprot) of card SAMS_CARD.
//   - Mapper registers live at CPU >4000..>401E while the SAMS card is
//     selected. Data is byte-swapped: the high byte holds the low 8 page bits.
//   - Page translation for the 16 4K regions, combinational in bank_sel.
//   Optional: define SAMS_PAIR_AUTOINC_EN so that a write to an even register
//   n also loads reg[n+1] with page+1.
// Ports
//   clk, reset                  system clock, async active-high reset
//   cruclk/cru_addr/cruout      CPU CRU write strobe (async), bit address, data
//   cruin, cruin_oe             CRU read data and its drive enable
//   mem_addr/we/re/wdata        CPU memory cycle (one-clk strobes)
//   mem_rdata, mem_rvalid       register read-back, valid one clk after mem_re
//   reg_hit                     cycle targets mapper registers
//   card_sel                    one-hot DSR select
//   bank_sel                    CPU A0-A3 of the current access
//   bank_mapped/readonly/address translation result
module cru_sams_mapper #(
  parameter int          PAGE_BITS = 8,
  parameter int          NUM_CARDS = 16,
  parameter int          SAMS_CARD = 14,
  parameter logic [15:0] MAP_MASK  = 16'hFC0C
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cruclk,
  input  logic [14:0]          cru_addr,
  input  logic                 cruout,
  output logic                 cruin,
  output logic                 cruin_oe,
  input  logic [15:0]          mem_addr,
  input  logic                 mem_we,
  input  logic                 mem_re,
  input  logic [15:0]          mem_wdata,
  output logic [15:0]          mem_rdata,
  output logic                 mem_rvalid,
  output logic                 reg_hit,
  output logic [NUM_CARDS-1:0] card_sel,
  input  logic [3:0]           bank_sel,
  output logic                 bank_mapped,
  output logic                 bank_readonly,
  output logic [PAGE_BITS-1:0] bank_address
);

  // cruclk synchroniser: [0],[1] metastability flops, [2] edge history.
  logic [2:0] cru_pipe;
  logic       cru_rise;

  always_ff @(posedge clk or posedge reset)
    if (reset) cru_pipe <= '0;
    else       cru_pipe <= {cru_pipe[1:0], cruclk};

  assign cru_rise = cru_pipe[1] & ~cru_pipe[2];

  // CRU decode
  logic        cru_exp, card_ok;
  logic [3:0]  cru_card;
  logic [6:0]  cru_bit;
  logic [15:0] sel_pad;
  logic        transparent, wprot;

  assign cru_exp  = (cru_addr[14:11] == 4'b0001);
  assign cru_card = cru_addr[10:7];
  assign cru_bit  = cru_addr[6:0];
  assign card_ok  = cru_exp && (int'(cru_card) < NUM_CARDS);
  assign cruin_oe = card_ok;

  // card_sel widened to 16 so any 4-bit card index can be read safely
  always_comb begin
    sel_pad                = '0;
    sel_pad[NUM_CARDS-1:0] = card_sel;
  end

  always_comb begin
    cruin = 1'b0;
    if (card_ok) begin
      if (cru_bit == 7'd0)                                       cruin = sel_pad[cru_card];
      else if (cru_card == 4'(SAMS_CARD) && cru_bit == 7'd1)     cruin = transparent;
      else if (cru_card == 4'(SAMS_CARD) && cru_bit == 7'd2)     cruin = wprot;
    end
  end

  // CRU writes land on the cycle the synchronised edge is seen; cru_addr and
  // cruout are sampled on that same clock, so they must be held across it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      card_sel    <= '0;
      transparent <= 1'b1;
      wprot       <= 1'b0;
    end else if (cru_rise && card_ok) begin
      if (cru_bit == 7'd0) begin
        for (int n = 0; n < NUM_CARDS; n++) begin
          if (cruout)                  card_sel[n] <= (4'(n) == cru_card);
          else if (4'(n) == cru_card)  card_sel[n] <= 1'b0;
        end
      end
      if (cru_card == 4'(SAMS_CARD)) begin
        if (cru_bit == 7'd1) transparent <= cruout;
        if (cru_bit == 7'd2) wprot       <= cruout;
      end
    end
  end

  // Register window
  logic [3:0]                  idx;
  logic [15:0]                 swapped;
  logic [PAGE_BITS-1:0]        wpage;
  logic                        wr_en;
  logic [15:0]                 rd_ext;
  logic [15:0][PAGE_BITS-1:0]  map_reg;
  logic                        unused_bits;

  assign reg_hit     = card_sel[SAMS_CARD] && (mem_addr[15:5] == 11'h200);
  assign idx         = mem_addr[4:1];
  assign swapped     = {mem_wdata[7:0], mem_wdata[15:8]};
  assign wpage       = swapped[PAGE_BITS-1:0];
  assign wr_en       = mem_we && reg_hit && !wprot;
  assign rd_ext      = 16'(map_reg[idx]);
  assign unused_bits = ^{mem_addr[0], swapped};

  // Reset to identity so map mode before programming matches transparent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 16; n++) map_reg[n] <= PAGE_BITS'(n);
    end else if (wr_en) begin
      map_reg[idx] <= wpage;
`ifdef SAMS_PAIR_AUTOINC_EN
      if (!idx[0]) map_reg[idx | 4'd1] <= wpage + PAGE_BITS'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= mem_re && reg_hit;
      if (mem_re && reg_hit) mem_rdata <= {rd_ext[7:0], rd_ext[15:8]};
    end
  end

  // Translation
  always_comb begin
    bank_mapped   = MAP_MASK[bank_sel];
    bank_readonly = 1'b0;
    bank_address  = '0;
    if (MAP_MASK[bank_sel]) begin
      if (transparent) begin
        bank_address = PAGE_BITS'(bank_sel);
      end else begin
        bank_address  = map_reg[bank_sel];
        bank_readonly = wprot;
      end
    end
  end

endmodule

// File: tb/tb_cru_sams_mapper.sv
module tb_cru_sams_mapper;
  logic        clk, reset, cruclk, cruout, cruin, cruin_oe;
  logic [14:0] cru_addr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, mem_rvalid, reg_hit;
  logic [15:0] card_sel;
  logic [3:0]  bank_sel;
  logic        bank_mapped, bank_readonly;
  logic [7:0]  bank_address;

  logic [15:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  cru_sams_mapper dut (
    .clk(clk), .reset(reset), .cruclk(cruclk), .cru_addr(cru_addr),
    .cruout(cruout), .cruin(cruin), .cruin_oe(cruin_oe),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .reg_hit(reg_hit), .card_sel(card_sel), .bank_sel(bank_sel),
    .bank_mapped(bank_mapped), .bank_readonly(bank_readonly),
    .bank_address(bank_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic sb_push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic cru_pulse(input logic [14:0] a, input logic d);
    @(negedge clk);
    cru_addr = a; cruout = d; cruclk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cruclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [15:0] d, input logic hit);
    @(negedge clk);
    mem_addr = a; mem_wdata = d; mem_we = 1'b1;
    sb_push({15'd0, hit});
    #1 chk("reg_hit", {15'd0, reg_hit});
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic mem_read(input logic [15:0] a, input logic vld, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a; mem_re = 1'b1;
    sb_push({15'd0, vld});
    if (vld) sb_push(d);
    @(posedge clk);
    #1 chk("rvalid", {15'd0, mem_rvalid});
    if (vld) chk("rdata", mem_rdata);
    @(negedge clk);
    mem_re = 1'b0;
    sb_push(16'd0);
    @(posedge clk);
    #1 chk("rvalid_drop", {15'd0, mem_rvalid});
  endtask

  task automatic bank_chk(input logic [3:0] b, input logic m, input logic ro, input logic [7:0] a);
    @(negedge clk);
    bank_sel = b;
    sb_push({15'd0, m}); sb_push({15'd0, ro}); sb_push({8'd0, a});
    #1;
    chk("bank_mapped", {15'd0, bank_mapped});
    chk("bank_readonly", {15'd0, bank_readonly});
    chk("bank_address", {8'd0, bank_address});
  endtask

  task automatic sel_chk(input string tag, input logic [15:0] v);
    sb_push(v);
    chk(tag, card_sel);
  endtask

  task automatic cruin_chk(input logic [14:0] a, input logic v, input logic oe);
    @(negedge clk);
    cru_addr = a;
    sb_push({15'd0, v}); sb_push({15'd0, oe});
    #1;
    chk("cruin", {15'd0, cruin});
    chk("cruin_oe", {15'd0, cruin_oe});
  endtask

  initial begin
    reset = 1'b1; cruclk = 1'b0; cru_addr = '0; cruout = 1'b0;
    mem_addr = '0; mem_we = 1'b0; mem_re = 1'b0; mem_wdata = '0; bank_sel = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    sel_chk("reset_card_sel", 16'h0000);
    sb_push(16'd0); chk("reset_rvalid", {15'd0, mem_rvalid});
    sb_push(16'd0); chk("reset_rdata", mem_rdata);
    cruin_chk(15'h0F01, 1'b1, 1'b1);
    cruin_chk(15'h1F01, 1'b0, 1'b0);
    bank_chk(4'd2, 1'b1, 1'b0, 8'h02);
    bank_chk(4'd4, 1'b0, 1'b0, 8'h00);

    // card 1 select, latency check: not yet after 2 clocks, set after 3
    @(negedge clk);
    cru_addr = 15'h0880; cruout = 1'b1; cruclk = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 sel_chk("card1_early", 16'h0000);
    @(posedge clk);
    #1 sel_chk("card1_sel", 16'h0002);
    @(negedge clk); cruclk = 1'b0;
    repeat (3) @(negedge clk);
    cruin_chk(15'h0880, 1'b1, 1'b1);

    // card 3 takes over
    cru_pulse(15'h0980, 1'b1);
    sel_chk("card3_sel", 16'h0008);
    cruin_chk(15'h0880, 1'b0, 1'b1);

    // select mapper card, program reg 10, enter map mode
    cru_pulse(15'h0F00, 1'b1);
    sel_chk("sams_sel", 16'h4000);
    mem_write(16'h4014, 16'h4200, 1'b1);
    cru_pulse(15'h0F01, 1'b0);
    cruin_chk(15'h0F01, 1'b0, 1'b1);
    bank_chk(4'd10, 1'b1, 1'b0, 8'h42);
    bank_chk(4'd3, 1'b1, 1'b0, 8'h03);
    bank_chk(4'd1, 1'b0, 1'b0, 8'h00);
    mem_read(16'h4014, 1'b1, 16'h4200);

    // write protect
    cru_pulse(15'h0F02, 1'b1);
    cruin_chk(15'h0F02, 1'b1, 1'b1);
    mem_write(16'h4014, 16'h1100, 1'b1);
    bank_chk(4'd10, 1'b1, 1'b1, 8'h42);
    bank_chk(4'd4, 1'b0, 1'b0, 8'h00);
    cru_pulse(15'h0F02, 1'b0);
    bank_chk(4'd10, 1'b1, 1'b0, 8'h42);

    // mapper deselected: no register hits
    cru_pulse(15'h0F00, 1'b0);
    sel_chk("sams_desel", 16'h0000);
    mem_write(16'h4002, 16'h7700, 1'b0);
    mem_write(16'h4006, 16'h5500, 1'b0);
    bank_chk(4'd3, 1'b1, 1'b0, 8'h03);
    mem_read(16'h4002, 1'b0, 16'h0000);
    cru_pulse(15'h0F00, 1'b1);
    mem_read(16'h4002, 1'b1, 16'h0100);

    // even/odd pair, wrap
    mem_write(16'h4018, 16'hFF00, 1'b1);
    bank_chk(4'd12, 1'b1, 1'b0, 8'hFF);
`ifdef SAMS_PAIR_AUTOINC_EN
    bank_chk(4'd13, 1'b1, 1'b0, 8'h00);
`else
    bank_chk(4'd13, 1'b1, 1'b0, 8'h0D);
`endif
    mem_write(16'h401A, 16'h3300, 1'b1);
    bank_chk(4'd13, 1'b1, 1'b0, 8'h33);
    mem_read(16'h4018, 1'b1, 16'hFF00);

    // back-to-back writes, last wins
    @(negedge clk);
    mem_addr = 16'h4014; mem_wdata = 16'h1100; mem_we = 1'b1;
    @(negedge clk);
    mem_wdata = 16'h2200;
    @(negedge clk);
    mem_we = 1'b0;
    bank_chk(4'd10, 1'b1, 1'b0, 8'h22);

    // deselect and register write on the same clock: write uses old select
    @(negedge clk);
    cru_addr = 15'h0F00; cruout = 1'b0; cruclk = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    mem_addr = 16'h4016; mem_wdata = 16'h6600; mem_we = 1'b1;
    @(posedge clk);
    #1 sel_chk("simul_desel", 16'h0000);
    @(negedge clk);
    mem_we = 1'b0; cruclk = 1'b0;
    repeat (3) @(negedge clk);
    bank_chk(4'd11, 1'b1, 1'b0, 8'h66);

    // reset in the middle of a CRU pulse
    @(negedge clk);
    cru_addr = 15'h0F00; cruout = 1'b1; cruclk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 sel_chk("reset_mid", 16'h0000);
    @(negedge clk);
    cruclk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    sel_chk("post_reset_sel", 16'h0000);
    bank_chk(4'd10, 1'b1, 1'b0, 8'h0A);
    cruin_chk(15'h0F01, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
